// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the RAM port arbiter
package mem_port_arbiter_pkg;

  // Width of the fetch starvation counter; STARVE_LIMIT must fit in it (1..15).
  localparam int STARVE_CNT_W = 4;

  // Who owns the RAM response arriving in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// rtl/mem_port_arbiter_starve_counter.sv - saturating count of data grants taken while fetch waits
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt;

  // Hold wins over clear/increment so a stalled RAM freezes the fairness state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port RAM arbiter between instruction fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [29:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic [29:0] d_addr_i,
  input  logic [3:0]  d_wen_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  input  logic        ram_ready_i,
  output logic [29:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_wen_o,
  output logic        ram_ren_o,
  input  logic [31:0] ram_rdata_i
);

  logic   fetch_first;
  owner_t owner;
  owner_t owner_next;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk_i),
    .rst      (rst_i),
    .inc      (d_gnt_o && if_req_i),
    .clr      (if_gnt_o || !if_req_i),
    .hold     (!ram_ready_i),
    .at_limit (fetch_first)
  );

  // Data has priority unless fetch has been starved for STARVE_LIMIT grants; no grants in reset.
  always_comb begin
    if_gnt_o = !rst_i && ram_ready_i && if_req_i && (!d_req_i || fetch_first);
    d_gnt_o  = !rst_i && ram_ready_i && d_req_i && !if_gnt_o;
  end

  // Steer the granted port onto the RAM; everything idles at zero otherwise.
  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wen_o   = '0;
    ram_ren_o   = 1'b0;
    if (if_gnt_o) begin
      ram_addr_o = if_addr_i;
      ram_ren_o  = 1'b1;
    end else if (d_gnt_o) begin
      ram_addr_o = d_addr_i;
      if (d_wen_i == 4'b0000) begin
        ram_ren_o = 1'b1;
      end else begin
        ram_wen_o   = d_wen_i;
        ram_wdata_o = d_wdata_i;
      end
    end
  end

  // Next owner is simply what was granted this cycle.
  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt_o) begin
      owner_next = OWN_IF;
    end else if (d_gnt_o) begin
      owner_next = (d_wen_i == 4'b0000) ? OWN_DRD : OWN_DWR;
    end
  end

  // Owner register: one-cycle record of the access whose response returns next.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner <= OWN_NONE;
    end else begin
      owner <= owner_next;
    end
  end

  // Route the RAM response to its owner; a reset cycle drops any in-flight response.
  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    if (!rst_i) begin
      case (owner)
        OWN_IF: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = ram_rdata_i;
        end
        OWN_DRD: begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = ram_rdata_i;
        end
        OWN_DWR: begin
          d_rvalid_o = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
